// File: rtl/reg_observe_display.sv
// Register-observe front panel: two debounced buttons step the observed register index, and an
// 8-digit multiplexed 7-segment display shows data_ob or pc. Optional macro: OBSERVE_IDX_EN.
module reg_observe_display #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DB_CYCLES    = 20000,
  parameter int unsigned OBSERVE_INIT = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        show_pc,
  input  logic [31:0] data_ob,
  input  logic [31:0] pc,
  output logic [4:0]  observe,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]      btn_raw;
  logic [1:0]      sync1, sync2;
  logic [1:0]      deb;
  logic [1:0]      arm;
  logic [1:0]      differ, accept, step;
  logic [DB_W-1:0] db_cnt [2];

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic             started;
  logic             div_term;
  logic [31:0]      disp_val;
  logic [31:0]      shown;
  logic [3:0]       nib;

  assign btn_raw = {btn_prev, btn_next};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Synchronizers are left out of reset so a button held through reset is still seen as held.
  always_ff @(posedge clk) begin
    sync1 <= btn_raw;
    sync2 <= sync1;
  end

  always_comb begin
    differ = '0;
    accept = '0;
    step   = '0;
    for (int i = 0; i < 2; i++) begin
      differ[i] = sync2[i] ^ deb[i];
      accept[i] = differ[i] && (db_cnt[i] == DB_W'(DB_CYCLES - 1));
      step[i]   = accept[i] && sync2[i] && arm[i];
    end
  end

  // A button only arms after a released level is seen, so a press held across reset never steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb     <= '0;
      arm     <= '0;
      db_cnt  <= '{default: '0};
      observe <= 5'(OBSERVE_INIT);
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else if (differ[i]) begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end else begin
          db_cnt[i] <= '0;
        end
        if (!sync2[i] && !deb[i]) begin
          arm[i] <= 1'b1;
        end
      end
      case (step)
        2'b01:   observe <= observe + 5'd1;
        2'b10:   observe <= observe - 5'd1;
        default: observe <= observe;
      endcase
    end
  end

  assign div_term = (div == DIV_W'(SCAN_DIV - 1));

  // Scan timing and frame latch; disp_val only changes at the 7->0 wrap or right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      idx      <= '0;
      started  <= 1'b0;
      disp_val <= '0;
    end else begin
      started <= 1'b1;
      if (div_term) begin
        div <= '0;
        idx <= idx + 3'd1;
      end else begin
        div <= div + DIV_W'(1);
      end
      if (!started || (div_term && (idx == 3'd7))) begin
        disp_val <= show_pc ? pc : data_ob;
      end
    end
  end

  always_comb begin
    shown = disp_val;
`ifdef OBSERVE_IDX_EN
    if (!show_pc) begin
      shown[31:24] = {3'b000, observe};
    end
`endif
    nib = shown[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (started) begin
      an  <= ~(8'b0000_0001 << idx);
      seg <= hex7(nib);
      dp  <= !((idx == 3'd7) && show_pc);
    end
  end

endmodule

// File: tb/tb_reg_observe_display.sv
// Randomized bench for reg_observe_display, checked every cycle against a cycle-count based model.
module tb_reg_observe_display;

  localparam int SD = 2;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_next, btn_prev, show_pc;
  logic [31:0] data_ob, pc;
  logic [4:0]  observe;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;

  reg_observe_display #(.SCAN_DIV(SD), .DB_CYCLES(DB), .OBSERVE_INIT(20)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev), .show_pc(show_pc),
    .data_ob(data_ob), .pc(pc), .observe(observe), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state: cycles since reset release, latched frame, expected index, button history.
  int          k = 0;
  logic [31:0] mdisp = '0;
  logic [4:0]  mobs = 5'd20;
  bit          b1 [2];
  bit          b2 [2];
  bit          dlvl [2];
  int          run [2];
  bit          armed [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  nb;
    logic [31:0] ov;
    int          d;
    bit          sync [2];
    bit          stp [2];
    bit          arm_set;
    @(posedge clk);
    sync[0] = b2[0];
    sync[1] = b2[1];
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    if (reset) begin
      k = 0;
      mobs = 5'd20;
      for (int i = 0; i < 2; i++) begin
        dlvl[i] = 1'b0; run[i] = 0; armed[i] = 1'b0;
      end
    end else begin
      k++;
      if (k > 1) begin
        d = ((k - 1) / SD) % 8;
        e_an = ~(8'(1) << d);
        nb = 4'(mdisp >> (4 * d));
`ifdef OBSERVE_IDX_EN
        if (!show_pc && d >= 6) begin
          ov = {27'd0, mobs};
          nb = 4'(ov >> (4 * (d - 6)));
        end
`endif
        e_seg = hex_lut[nb];
        e_dp = !(d == 7 && show_pc);
      end
      for (int i = 0; i < 2; i++) begin
        stp[i] = 1'b0;
        arm_set = !sync[i] && !dlvl[i];
        if (sync[i] != dlvl[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            dlvl[i] = sync[i];
            run[i] = 0;
            stp[i] = sync[i] && armed[i];
          end
        end else begin
          run[i] = 0;
        end
        if (arm_set) armed[i] = 1'b1;
      end
      if (stp[0] && !stp[1]) mobs = mobs + 5'd1;
      else if (stp[1] && !stp[0]) mobs = mobs - 5'd1;
      if (k == 1 || (k % (8 * SD)) == 0) mdisp = show_pc ? pc : data_ob;
    end
    b2[0] = b1[0]; b2[1] = b1[1];
    b1[0] = btn_next; b1[1] = btn_prev;
    #1;
    check("observe", 32'(observe), 32'(mobs));
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
  endtask

  task automatic press(input bit nxt, input bit prv, input int n);
    btn_next = nxt; btn_prev = prv;
    repeat (n) tick();
    btn_next = 1'b0; btn_prev = 1'b0;
    repeat (n) tick();
  endtask

  task automatic scan_check(input string tag, input logic [6:0] exp0, input logic [6:0] exp7);
    int seen = 0;
    repeat (16) begin
      tick();
      if (an == 8'hFE) begin check({tag, "_dig0"}, 32'(seg), 32'(exp0)); seen++; end
      if (an == 8'h7F) begin check({tag, "_dig7"}, 32'(seg), 32'(exp7)); seen++; end
    end
    check({tag, "_seen"}, 32'(seen), 32'd4);
  endtask

  initial begin
    int hold [2];
    bit lvl [2];
    reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; show_pc = 1'b0;
    data_ob = '0; pc = '0;
    repeat (3) tick();
    check("rst_observe", 32'(observe), 32'd20);
    reset = 1'b0;
    tick();
    check("first_an", 32'(an), 32'hFF);
    tick();
    check("second_an", 32'(an), 32'hFE);

    press(1'b1, 1'b0, 10);
    check("next_once", 32'(observe), 32'd21);
    press(1'b1, 1'b0, 10);
    check("next_twice", 32'(observe), 32'd22);
    press(1'b0, 1'b1, 2);
    repeat (8) tick();
    check("short_pulse", 32'(observe), 32'd22);

    repeat (9) press(1'b1, 1'b0, 8);
    check("at31", 32'(observe), 32'd31);
    press(1'b1, 1'b0, 8);
    check("wrap_up", 32'(observe), 32'd0);
    press(1'b0, 1'b1, 8);
    check("wrap_down", 32'(observe), 32'd31);
    press(1'b1, 1'b1, 8);
    check("both", 32'(observe), 32'd31);

    show_pc = 1'b0; data_ob = 32'h12345678;
    repeat (40) tick();
    scan_check("data", 7'b0000000, 7'b1111001);
    repeat (5) tick();
    data_ob = 32'hFFFFFFFF;
    repeat (40) tick();
    scan_check("data_ff", 7'b0001110, 7'b0001110);

    show_pc = 1'b1; pc = 32'h00400000;
    repeat (40) tick();
    scan_check("pc", 7'b1000000, 7'b1000000);
    show_pc = 1'b0;

    btn_next = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midrst_an", 32'(an), 32'hFF);
    reset = 1'b0;
    repeat (20) tick();
    check("held_no_step", 32'(observe), 32'd20);
    btn_next = 1'b0;
    repeat (10) tick();
    press(1'b1, 1'b0, 10);
    check("rearm_step", 32'(observe), 32'd21);

    repeat (4) press(1'b0, 1'b1, 8);
    check("obs17", 32'(observe), 32'd17);
    data_ob = 32'h11AAAAAA;
    repeat (40) tick();
    scan_check("idx", 7'b0001000, 7'b1111001);

    hold[0] = 0; hold[1] = 0;
    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 12);
        end
        hold[i]--;
      end
      btn_next = lvl[0]; btn_prev = lvl[1];
      if ($urandom_range(0, 9) == 0) data_ob = $urandom;
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      if ($urandom_range(0, 49) == 0) show_pc = ~show_pc;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
